// File: rtl/dmi_pkg.sv
// Shared DMI types and constants for the DTM-side DMI controller.
package dmi_pkg;

  localparam int unsigned DMI_ABITS = 7;

  typedef enum logic [1:0] {
    OpNop   = 2'd0,
    OpRead  = 2'd1,
    OpWrite = 2'd2,
    OpRsvd  = 2'd3
  } dmi_op_t;

  typedef enum logic [1:0] {
    StatOk     = 2'd0,
    StatFailed = 2'd2,
    StatBusy   = 2'd3
  } dmi_status_t;

  typedef struct packed {
    logic [DMI_ABITS-1:0] addr;
    logic [31:0]          data;
    dmi_op_t              op;
  } dmi_req_t;

  // Only reads and writes start a bus transaction; nop and reserved do not.
  function automatic logic op_is_access(dmi_op_t op);
    return (op == OpRead) || (op == OpWrite);
  endfunction

endpackage

// File: rtl/dmi_timeout_counter.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module dmi_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry and next count: restart on clear or once expired.
  always_comb begin
    expired_o = en_i && (cnt_q == CntLast);
    cnt_d     = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmi_controller.sv
// Turns completed DMI scans into DM req/resp transactions, builds the
// capture word for the next scan and keeps the sticky dmistat.
module dmi_controller
  import dmi_pkg::*;
#(
  parameter int unsigned ABITS          = DMI_ABITS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_valid_i,
  input  logic [ABITS+33:0] upd_data_i,
  input  logic             cap_strobe_i,
  output logic [ABITS+33:0] cap_data_o,
  input  logic             dmireset_i,
  input  logic             dmihardreset_i,
  output logic [1:0]       dmistat_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_op_i,
  output logic             resp_ready_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;

  state_e            state_q;
  logic              req_valid_q;
  logic [ABITS-1:0]  req_addr_q;
  logic [31:0]       req_data_q;
  dmi_op_t           req_op_q;
  dmi_status_t       dmistat_q, stat_clr, stat_evt, stat_d;
  logic [ABITS-1:0]  last_addr_q;
  logic [31:0]       last_rdata_q, rdata_new;
  logic [ABITS+33:0] cap_data_q;
  logic [1:0]        cap_status;

  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_wdata;
  dmi_op_t          upd_op;
  logic             resp_hit, rdata_load, timeout_hit, upd_accept, upd_busy, cap_idle;
  logic             cnt_en, cnt_clr;

  assign upd_addr  = upd_data_i[ABITS+33:34];
  assign upd_wdata = upd_data_i[33:2];
  assign upd_op    = dmi_op_t'(upd_data_i[1:0]);

  assign resp_hit   = (state_q == StWaitResp) && resp_valid_i && !dmihardreset_i;
  assign rdata_load = resp_hit && (req_op_q == OpRead);
  assign rdata_new  = rdata_load ? resp_data_i : last_rdata_q;
  // A response landing with a capture counts as idle for that capture.
  assign cap_idle   = (state_q == StIdle) || resp_hit || dmihardreset_i;
  assign upd_busy   = upd_valid_i && (state_q != StIdle) && !dmihardreset_i;

  assign cnt_en  = (state_q == StWaitResp) && !resp_valid_i && !dmihardreset_i;
  assign cnt_clr = (state_q != StWaitResp) || dmihardreset_i;

  dmi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (cnt_en),
    .clr_i    (cnt_clr),
    .expired_o(timeout_hit)
  );

  // dmistat priority: hard reset, then dmireset clear, then any error/busy set.
  always_comb begin
    stat_clr   = dmireset_i ? StatOk : dmistat_q;
    upd_accept = upd_valid_i && (state_q == StIdle) && (stat_clr == StatOk) && !dmihardreset_i;
    stat_evt   = stat_clr;
    if (upd_busy && (stat_clr == StatOk)) begin
      stat_evt = StatBusy;
    end
    if (resp_hit) begin
      if (resp_op_i == 2'd2) begin
        stat_evt = StatFailed;
      end else if (resp_op_i == 2'd3) begin
        stat_evt = StatBusy;
      end
    end
    if (timeout_hit) begin
      stat_evt = StatFailed;
    end
    cap_status = cap_idle ? stat_evt : StatBusy;
    stat_d     = stat_evt;
    if (cap_strobe_i && !cap_idle && !timeout_hit) begin
      stat_d = StatBusy;
    end
    if (dmihardreset_i) begin
      stat_d     = StatOk;
      cap_status = StatOk;
    end
  end

  // Transaction FSM with registered request, status and capture outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_op_q     <= OpNop;
      dmistat_q    <= StatOk;
      last_addr_q  <= '0;
      last_rdata_q <= '0;
      cap_data_q   <= '0;
    end else begin
      dmistat_q <= stat_d;
      if (rdata_load) begin
        last_rdata_q <= resp_data_i;
      end
      if (cap_strobe_i) begin
        cap_data_q <= {last_addr_q, rdata_new, cap_status};
      end
      if (dmihardreset_i) begin
        state_q     <= StIdle;
        req_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (upd_accept) begin
              last_addr_q <= upd_addr;
              if (op_is_access(upd_op)) begin
                req_addr_q  <= upd_addr;
                req_data_q  <= upd_wdata;
                req_op_q    <= upd_op;
                req_valid_q <= 1'b1;
                state_q     <= StReq;
              end
            end
          end
          StReq: begin
            if (req_ready_i) begin
              req_valid_q <= 1'b0;
              state_q     <= StWaitResp;
            end
          end
          StWaitResp: begin
            if (resp_hit || timeout_hit) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cap_data_o   = cap_data_q;
  assign dmistat_o    = dmistat_q;
  assign req_valid_o  = req_valid_q;
  assign req_addr_o   = req_addr_q;
  assign req_data_o   = req_data_q;
  assign req_op_o     = req_op_q;
  assign resp_ready_o = 1'b1;

endmodule

// File: doc/dmi_controller.md
Name: dmi_controller

Overview:
- Downstream neighbour of the JTAG TAP/DTM shift logic; consumes completed 41-bit DMI scans `{addr[6:0], data[31:0], op[1:0]}` presented at Update-DR.
- Issues the scans as req/resp transactions to the Debug Module on the Debug Module Interface (DMI).
- Returns the capture word for the next DMI scan and maintains the sticky `dmistat` reported through DTMCS.
- Single clock domain, shared with the Debug Module.

Parameters:
- ABITS, 7, DMI address width.
- TIMEOUT_CYCLES, 1024, cycles in WAIT_RESP before the op is declared failed; must be ≥ 2.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- upd_valid  in  1  one-cycle pulse: Update-DR with IR = DMI.
- upd_data  in  ABITS+34  scanned word `{addr, data, op}`.
- cap_strobe  in  1  one-cycle pulse: Capture-DR with IR = DMI.
- cap_data  out  ABITS+34  `{last_addr, last_rdata, status}` for shifting out.
- dmireset  in  1  pulse: DTMCS write with `dmireset` = 1.
- dmihardreset  in  1  pulse: DTMCS write with `dmihardreset` = 1.
- dmistat  out  2  sticky status for DTMCS (0 ok, 2 failed, 3 busy).
- req_valid  out  1  DMI request valid.
- req_ready  in  1  DM accepts the request.
- req_addr  out  ABITS  request address.
- req_data  out  32  request write data.
- req_op  out  2  1 = read, 2 = write.
- resp_valid  in  1  DM response valid.
- resp_data  out... in  32  read data.
- resp_op  in  2  0 = ok, 2 = failed, 3 = busy.
- resp_ready  out  1  tied to 1; responses are always accepted.

Behaviour:
- **Reset values.** `req_valid` = 0, `req_addr` = 0, `req_data` = 0, `req_op` = 0, `dmistat` = 0, `cap_data` = 0, state = IDLE, timeout counter = 0.
- **States.**
  - IDLE → REQ on an accepted update.
  - REQ → WAIT_RESP on `req_valid & req_ready`.
  - WAIT_RESP → IDLE on `resp_valid`, or on timeout.
- **Accepting an update.** An update is accepted only in IDLE with `dmistat` == 0.
  - op 0 (nop): no DMI transaction; `last_addr` is updated; state stays IDLE.
  - op 3 (reserved): treated as nop.
  - op 1 or 2: latch addr, data and op into `req_*`, enter REQ. `req_valid` rises the cycle after `upd_valid`.
- **Update while not IDLE.** An update arriving in REQ or WAIT_RESP is ignored and `dmistat` is set to 3 (busy).
- **Update while `dmistat` != 0.** The update is ignored; `dmistat` is unchanged.
- **REQ handshake.** `req_valid` and `req_*` are held stable until `req_ready`. `req_valid` drops the cycle after the handshake.
- **WAIT_RESP, response arrives.** On `resp_valid`:
  - a read latches `resp_data` into `last_rdata`;
  - `resp_op` 2 sets `dmistat` = 2; `resp_op` 3 sets `dmistat` = 3;
  - 0 leaves `dmistat` unchanged (sticky);
  - return to IDLE the next cycle.
- **Timeout.** The counter counts cycles in WAIT_RESP. On reaching `TIMEOUT_CYCLES` set `dmistat` = 2 and return to IDLE.
  - Any later stray `resp_valid` outside WAIT_RESP is dropped with no effect.
- **Capture.** On `cap_strobe`, register `cap_data` = `{last_addr, last_rdata, status}`.
  - status = 3 if state ≠ IDLE, and `dmistat` is also set to 3.
  - Otherwise status = `dmistat`.
  - `cap_data` is stable until the next `cap_strobe`.
- **dmireset.** Clears `dmistat` to 0; does not abort an in-flight transaction.
- **dmihardreset.** Forces state to IDLE, deasserts `req_valid`, clears `dmistat` and the timeout counter. Any response for the aborted transaction is dropped.
- **Simultaneous events, same cycle.**
  - `dmihardreset` has highest priority.
  - Then `dmireset` (clear), then an error/busy set in the same cycle — the set wins.
  - `upd_valid` together with `dmireset` is evaluated after the clear, so the update is accepted if IDLE.
  - `resp_valid` together with `cap_strobe` is treated as IDLE for capture. The capture sees the new `last_rdata` (bypassed).
- **Reset mid-transaction.** `rst` returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared package `dmi_pkg` holds:
  - `dmi_op_t` (NOP = 0, READ = 1, WRITE = 2, RSVD = 3);
  - `dmi_status_t` (OK = 0, FAILED = 2, BUSY = 3);
  - `dmi_req_t` struct `{addr, data, op}`;
  - constant `DMI_ABITS` = 7.
- One sub-module: `dmi_timeout_counter` (enable, clear, expired flag, parameterised by `TIMEOUT_CYCLES`).
- Everything else stays in `dmi_controller`.

Test Plan:
- Write: upd `{0x10, 0x00000001, 2}`, `req_ready` held 1, response op 0 after 3 cycles → one `req_valid` pulse with addr 0x10 and data 1; next capture returns status 0.
- Read: upd `{0x11, x, 1}`, response data 0xCAFEF00D op 0 → capture returns `{0x11, 0xCAFEF00D, 0}`.
- Busy: upd read with `resp_valid` withheld, then `cap_strobe` → capture status 3 and `dmistat` = 3.
  - A following upd is ignored (no second `req_valid`).
  - `dmireset` after the response → `dmistat` = 0.
- Timeout: withhold the response for `TIMEOUT_CYCLES` → state returns to IDLE and `dmistat` = 2.
  - A late `resp_valid` is ignored.
  - `dmihardreset` → `dmistat` = 0.
- Backpressure: `req_ready` low for 5 cycles → `req_*` stable throughout; exactly one handshake.
- Reset: assert `rst` while in WAIT_RESP → `req_valid` = 0 and `dmistat` = 0 immediately; the next upd is processed normally.
